// File: rtl/perifericos_bus_datos.sv
// Memory-mapped peripheral window on the data bus: output port, synchronized
// input port with change flag, prescaled compare timer and a registered interrupt.
module perifericos_bus_datos #(
  parameter logic [7:0] BASE = 8'hF0
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] Direccion_Dato,
  input  logic [7:0] Entrada_Datos,
  input  logic       RW,
  input  logic [7:0] Puerto_Entrada,
  output logic [7:0] Datos_Salida,
  output logic       Sel_Periferico,
  output logic       Lectura_Periferico,
  output logic [7:0] Puerto_Salida,
  output logic       Irq
);

  localparam logic [3:0] OFF_OUT   = 4'd0;
  localparam logic [3:0] OFF_IN    = 4'd1;
  localparam logic [3:0] OFF_CTRL  = 4'd2;
  localparam logic [3:0] OFF_PRESC = 4'd3;
  localparam logic [3:0] OFF_CMP   = 4'd4;
  localparam logic [3:0] OFF_CNT   = 4'd5;
  localparam logic [3:0] OFF_STAT  = 4'd6;

  logic [3:0] off;
  logic       wr;
  logic       rd;
  logic       wr_ctrl;
  logic       wr_presc;
  logic       wr_stat;

  // ctrl bits: 0 EN, 1 RECARGA, 2 IE_TMR, 3 IE_IN
  logic [3:0] ctrl;
  logic [7:0] presc;
  logic [7:0] cmp;
  logic [7:0] cnt;
  logic [7:0] pre;
  logic [7:0] sync_a;
  logic [7:0] sync_b;
  logic [7:0] in_prev;
  logic       tmr_f;
  logic       in_f;
  logic       tick;
  logic       match;
  logic [7:0] rd_mux;

  assign Sel_Periferico = (Direccion_Dato[7:4] == BASE[7:4]);
  assign off      = Direccion_Dato[3:0];
  assign wr       = RW & Sel_Periferico;
  assign rd       = ~RW & Sel_Periferico;
  assign wr_ctrl  = wr && (off == OFF_CTRL);
  assign wr_presc = wr && (off == OFF_PRESC);
  assign wr_stat  = wr && (off == OFF_STAT);

  assign tick  = ctrl[0] && (pre == presc);
  assign match = tick && (cnt == cmp);

  always_comb begin
    rd_mux = 8'h00;
    case (off)
      OFF_OUT:   rd_mux = Puerto_Salida;
      OFF_IN:    rd_mux = sync_b;
      OFF_CTRL:  rd_mux = {4'b0000, ctrl};
      OFF_PRESC: rd_mux = presc;
      OFF_CMP:   rd_mux = cmp;
      OFF_CNT:   rd_mux = cnt;
      OFF_STAT:  rd_mux = {6'b000000, in_f, tmr_f};
      default:   rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Puerto_Salida      <= 8'h00;
      ctrl               <= 4'h0;
      presc              <= 8'h00;
      cmp                <= 8'h00;
      cnt                <= 8'h00;
      pre                <= 8'h00;
      sync_a             <= 8'h00;
      sync_b             <= 8'h00;
      in_prev            <= 8'h00;
      tmr_f              <= 1'b0;
      in_f               <= 1'b0;
      Irq                <= 1'b0;
      Datos_Salida       <= 8'h00;
      Lectura_Periferico <= 1'b0;
    end else begin
      if (wr && (off == OFF_OUT)) Puerto_Salida <= Entrada_Datos;
      if (wr_presc) presc <= Entrada_Datos;
      if (wr && (off == OFF_CMP)) cmp <= Entrada_Datos;

      sync_a  <= Puerto_Entrada;
      sync_b  <= sync_a;
      in_prev <= sync_b;

      // Reconfiguring the prescale or control restarts the tick phase.
      if (wr_ctrl || wr_presc || !ctrl[0]) pre <= 8'h00;
      else if (pre == presc)               pre <= 8'h00;
      else                                 pre <= pre + 8'd1;

      if (wr_ctrl)                  ctrl    <= Entrada_Datos[3:0];
      else if (match && !ctrl[1])   ctrl[0] <= 1'b0;

      if (wr && (off == OFF_CNT)) cnt <= Entrada_Datos;
      else if (tick)              cnt <= match ? 8'h00 : cnt + 8'd1;

      // A new event on the clear edge keeps the flag set.
      tmr_f <= match | (tmr_f & ~(wr_stat & Entrada_Datos[0]));
      in_f  <= (sync_b != in_prev) | (in_f & ~(wr_stat & Entrada_Datos[1]));
      Irq   <= (tmr_f & ctrl[2]) | (in_f & ctrl[3]);

      Lectura_Periferico <= rd;
      if (rd) Datos_Salida <= rd_mux;
    end
  end

endmodule

// File: tb/tb_perifericos_bus_datos.sv
// Scoreboard bench: bus reads push expected data computed from a time-based
// model of the peripheral; a negedge monitor pops and compares each returned read.
module tb_perifericos_bus_datos;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [7:0] Direccion_Dato = 8'h00;
  logic [7:0] Entrada_Datos = 8'h00;
  logic       RW = 1'b0;
  logic [7:0] Puerto_Entrada = 8'h00;
  logic [7:0] Datos_Salida;
  logic       Sel_Periferico;
  logic       Lectura_Periferico;
  logic [7:0] Puerto_Salida;
  logic       Irq;

  perifericos_bus_datos #(.BASE(8'hF0)) dut (
    .Clk(Clk), .Rst(Rst), .Direccion_Dato(Direccion_Dato),
    .Entrada_Datos(Entrada_Datos), .RW(RW), .Puerto_Entrada(Puerto_Entrada),
    .Datos_Salida(Datos_Salida), .Sel_Periferico(Sel_Periferico),
    .Lectura_Periferico(Lectura_Periferico), .Puerto_Salida(Puerto_Salida),
    .Irq(Irq)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  // Model state; times are edge numbers (value of cyc after that edge).
  logic [7:0] m_out, m_presc, m_cmp, cnt_base;
  logic [3:0] m_ctrl;
  bit         sess_on, sess_rl;
  int         sess_start, tmr_last, tmr_clr, in_clr, last_wr;
  int         in_sets[$];
  int         pin_e[$];
  logic [7:0] pin_v[$];
  logic [7:0] cur_pin = 8'h00;

  logic [7:0] exp_q[$];
  int         off_q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Ticks between the match ticks: first match after m1 ticks, then every CMP+1.
  function automatic int m1_of();
    if (cnt_base <= m_cmp) return int'(m_cmp) - int'(cnt_base) + 1;
    return 256 - int'(cnt_base) + int'(m_cmp) + 1;
  endfunction

  function automatic int nticks(int t);
    int n;
    if (!sess_on || t < sess_start) return 0;
    n = (t - sess_start) / (int'(m_presc) + 1);
    if (!sess_rl && n > m1_of()) n = m1_of();
    return n;
  endfunction

  function automatic logic [7:0] cnt_at(int t);
    int n, m1;
    n = nticks(t);
    m1 = m1_of();
    if (n < m1) return 8'((int'(cnt_base) + n) % 256);
    return 8'((n - m1) % (int'(m_cmp) + 1));
  endfunction

  function automatic logic en_at(int t);
    return sess_on && (sess_rl || nticks(t) < m1_of());
  endfunction

  function automatic int last_match_edge(int t);
    int n, m1, k;
    n = nticks(t);
    m1 = m1_of();
    if (n < m1) return -1;
    k = m1 + ((n - m1) / (int'(m_cmp) + 1)) * (int'(m_cmp) + 1);
    return sess_start + k * (int'(m_presc) + 1);
  endfunction

  function automatic logic tmr_f_at(int t);
    if (tmr_last >= tmr_clr && tmr_last <= t) return 1'b1;
    return last_match_edge(t) >= tmr_clr;
  endfunction

  function automatic logic in_f_at(int t);
    foreach (in_sets[i]) if (in_sets[i] >= in_clr && in_sets[i] <= t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] in_at(int t);
    for (int i = pin_e.size() - 1; i >= 0; i--) if (pin_e[i] + 1 <= t) return pin_v[i];
    return 8'h00;
  endfunction

  function automatic logic [7:0] reg_at(logic [3:0] o, int t);
    case (o)
      4'd0: return m_out;
      4'd1: return in_at(t);
      4'd2: return {4'b0000, m_ctrl[3:1], en_at(t)};
      4'd3: return m_presc;
      4'd4: return m_cmp;
      4'd5: return cnt_at(t);
      4'd6: return {6'b000000, in_f_at(t), tmr_f_at(t)};
      default: return 8'h00;
    endcase
  endfunction

  task automatic close_sess(int e);
    int le;
    if (sess_on) begin
      le = last_match_edge(e);
      if (le >= 0) tmr_last = le;
      cnt_base = cnt_at(e);
      sess_on = 1'b0;
    end
  endtask

  task automatic model_write(logic [3:0] o, logic [7:0] d, int e);
    last_wr = e;
    case (o)
      4'd0: m_out = d;
      4'd2: begin
        close_sess(e);
        m_ctrl = d[3:0];
        if (d[0]) begin
          sess_on = 1'b1;
          sess_rl = d[1];
          sess_start = e;
        end
      end
      4'd3: begin close_sess(e); m_presc = d; end
      4'd4: begin close_sess(e); m_cmp = d; end
      4'd5: begin close_sess(e); cnt_base = d; end
      4'd6: begin
        if (d[0]) tmr_clr = e;
        if (d[1]) in_clr = e;
      end
      default: ;
    endcase
  endtask

  task automatic bus(input logic rw, input logic [7:0] a, input logic [7:0] d);
    int e;
    @(negedge Clk);
    RW = rw;
    Direccion_Dato = a;
    Entrada_Datos = d;
    #1 chk("sel", {7'b0, Sel_Periferico}, {7'b0, a[7:4] == 4'hF});
    @(posedge Clk);
    #1 e = cyc;
    RW = 1'b0;
    Direccion_Dato = 8'h00;
    if (a[7:4] == 4'hF) begin
      if (!rw) begin
        exp_q.push_back(reg_at(a[3:0], e - 1));
        off_q.push_back(int'(a[3:0]));
      end else begin
        model_write(a[3:0], d, e);
      end
    end
  endtask

  task automatic pin(input logic [7:0] v);
    @(negedge Clk);
    Puerto_Entrada = v;
    cur_pin = v;
    @(posedge Clk);
    #1;
    pin_e.push_back(cyc);
    pin_v.push_back(v);
    in_sets.push_back(cyc + 2);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    RW = 1'b0;
    Direccion_Dato = 8'h00;
    Puerto_Entrada = 8'h00;
    cur_pin = 8'h00;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    m_out = 8'h00; m_presc = 8'h00; m_cmp = 8'h00; cnt_base = 8'h00; m_ctrl = 4'h0;
    sess_on = 1'b0; sess_rl = 1'b0; sess_start = 0;
    tmr_last = -1; tmr_clr = 0; in_clr = 0; last_wr = cyc;
    in_sets.delete(); pin_e.delete(); pin_v.delete();
    started = 1'b1;
    chk("rst_datos", Datos_Salida, 8'h00);
    chk("rst_lect", {7'b0, Lectura_Periferico}, 8'h00);
    chk("rst_irq", {7'b0, Irq}, 8'h00);
    chk("rst_puerto", Puerto_Salida, 8'h00);
  endtask

  always @(negedge Clk) begin : monitor
    int t;
    logic ie;
    if (started) begin
      t = cyc;
      if (Lectura_Periferico === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read actual=1 required=0 cycle=%0d", t);
        end else begin
          chk($sformatf("rd_off%0d", off_q.pop_front()), Datos_Salida, exp_q.pop_front());
        end
      end
      chk("puerto_salida", Puerto_Salida, m_out);
      if (last_wr < t - 1) begin
        ie = (tmr_f_at(t - 1) & m_ctrl[2]) | (in_f_at(t - 1) & m_ctrl[3]);
        chk("irq", {7'b0, Irq}, {7'b0, ie});
      end
    end
  end

  initial begin
    logic [7:0] v;
    int r;
    do_reset();
    for (int i = 0; i < 16; i++) bus(1'b0, 8'hF0 + 8'(i), 8'h00);

    bus(1'b1, 8'hF0, 8'hA5);
    bus(1'b0, 8'hF0, 8'h00);
    bus(1'b1, 8'h10, 8'h3C);
    idle(2);

    // Auto-reload timer: PRESC=2, CMP=3.
    bus(1'b1, 8'hF3, 8'd2);
    bus(1'b1, 8'hF4, 8'd3);
    bus(1'b1, 8'hF2, 8'h07);
    for (int i = 0; i < 16; i++) bus(1'b0, 8'hF5, 8'h00);
    bus(1'b0, 8'hF6, 8'h00);
    bus(1'b1, 8'hF6, 8'h01);
    bus(1'b0, 8'hF6, 8'h00);
    idle(3);

    // One-shot.
    bus(1'b1, 8'hF2, 8'h00);
    bus(1'b1, 8'hF5, 8'h00);
    bus(1'b1, 8'hF6, 8'h01);
    bus(1'b1, 8'hF2, 8'h05);
    for (int i = 0; i < 20; i++) bus(1'b0, 8'hF5, 8'h00);
    bus(1'b0, 8'hF2, 8'h00);
    bus(1'b0, 8'hF6, 8'h00);

    // Input change detection and set-beats-clear.
    bus(1'b1, 8'hF2, 8'h08);
    pin(8'h81);
    bus(1'b0, 8'hF1, 8'h00);
    bus(1'b0, 8'hF1, 8'h00);
    idle(3);
    bus(1'b0, 8'hF6, 8'h00);
    bus(1'b1, 8'hF6, 8'h02);
    idle(3);
    pin(8'h18);
    idle(1);
    bus(1'b1, 8'hF6, 8'h02);
    bus(1'b0, 8'hF6, 8'h00);
    idle(4);

    // Reset while the timer is mid-count.
    bus(1'b1, 8'hF2, 8'h00);
    bus(1'b1, 8'hF5, 8'h00);
    bus(1'b1, 8'hF4, 8'd5);
    bus(1'b1, 8'hF3, 8'd2);
    bus(1'b1, 8'hF2, 8'h07);
    idle(7);
    do_reset();
    idle(10);
    bus(1'b0, 8'hF5, 8'h00);
    bus(1'b0, 8'hF2, 8'h00);
    bus(1'b0, 8'hF6, 8'h00);

    // Randomized rounds.
    for (int rnd = 0; rnd < 15; rnd++) begin
      bus(1'b1, 8'hF2, 8'h00);
      bus(1'b1, 8'hF3, 8'($urandom_range(0, 3)));
      bus(1'b1, 8'hF4, 8'($urandom_range(0, 5)));
      if ($urandom_range(0, 3) == 0) bus(1'b1, 8'hF5, 8'($urandom_range(0, 255)));
      else                           bus(1'b1, 8'hF5, 8'($urandom_range(0, 2)));
      bus(1'b1, 8'hF2, 8'($urandom_range(0, 255)) | 8'h01);
      repeat ($urandom_range(20, 60)) begin
        r = int'($urandom_range(0, 9));
        if (r <= 4) bus(1'b0, 8'hF0 | 8'($urandom_range(0, 15)), 8'h00);
        else if (r == 5) bus(1'b1, 8'hF0, 8'($urandom_range(0, 255)));
        else if (r == 6) bus(1'b1, 8'hF6, 8'($urandom_range(0, 255)));
        else if (r == 7) begin
          v = 8'($urandom_range(0, 255));
          if (v == cur_pin) v = ~cur_pin;
          pin(v);
        end else if (r == 8) idle(int'($urandom_range(1, 4)));
        else if ($urandom_range(0, 1) == 0)
          bus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 239)), 8'($urandom_range(0, 255)));
        else
          bus(1'b1, 8'hF7 + 8'($urandom_range(0, 8)), 8'($urandom_range(0, 255)));
      end
    end

    idle(3);
    chk("sb_empty", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
